// File: rtl/modn_pwm.sv
// PWM generator slaved to an external mod-N counter, with a shadowed duty
// register that only changes at the period wrap, and sequence checking on the count.
module modn_pwm #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [7:0]       periods,
  output logic             cnt_err,
  output logic             dbg_state
);

  // Duty handshake: a value is taken on any rising edge where duty_valid and
  // duty_ready are both high; duty_ready stays low while a value is pending.
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(N);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev_cnt;
  logic [WIDTH-1:0] r_active_duty;
  logic [WIDTH-1:0] r_pending_duty;
  logic             r_pending;
  logic             r_pwm;
  logic             r_period_start;
  logic [7:0]       r_periods;
  logic             r_cnt_err;

  logic [WIDTH-1:0] w_next_exp;
  logic [WIDTH-1:0] w_duty_clamped;
  logic             w_range_err;
  logic             w_seq_err;
  logic             w_err;
  logic             w_wrap;
  logic             w_accept;
  logic             w_shadow;
  logic             w_pwm_nxt;
  logic             w_ps_nxt;

  assign w_next_exp     = (r_prev_cnt == LP_LAST) ? '0 : r_prev_cnt + WIDTH'(1);
  assign w_range_err    = (cnt_in > LP_LAST);
  assign w_seq_err      = (r_state == RUN) && (cnt_in != w_next_exp);
  assign w_err          = w_range_err || w_seq_err;
  assign w_wrap         = (cnt_in == '0);
  assign w_accept       = duty_valid && !r_pending;
  assign w_shadow       = !w_err && r_pending && (cnt_in == LP_LAST);
  assign w_duty_clamped = (duty_in > LP_MAX) ? LP_MAX : duty_in;

  // The SYNC->RUN edge is still a SYNC edge, so its compare output stays 0;
  // it does raise period_start because it samples the wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_pwm_nxt   = 1'b0;
    w_ps_nxt    = 1'b0;
    if (w_err) begin
      w_state_nxt = SYNC;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_wrap) begin
            w_state_nxt = RUN;
            w_ps_nxt    = 1'b1;
          end
        end
        RUN: begin
          w_pwm_nxt = (cnt_in < r_active_duty);
          w_ps_nxt  = w_wrap;
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_prev_cnt     <= '0;
      r_active_duty  <= '0;
      r_pending_duty <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_periods      <= '0;
      r_cnt_err      <= 1'b0;
    end else begin
      r_prev_cnt     <= cnt_in;
      r_pwm          <= w_pwm_nxt;
      r_period_start <= w_ps_nxt;
      if (w_ps_nxt) begin
        r_periods <= r_periods + 8'd1;
      end
      if (w_err) begin
        r_cnt_err <= 1'b1;
      end
      // Shadow load and accept never collide: the load needs pending=1, the
      // accept needs pending=0.
      if (w_shadow) begin
        r_active_duty <= r_pending_duty;
        r_pending     <= 1'b0;
      end
      if (w_accept) begin
        r_pending_duty <= w_duty_clamped;
        r_pending      <= 1'b1;
      end
    end
  end

  assign duty_ready   = !r_pending;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign periods      = r_periods;
  assign cnt_err      = r_cnt_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_modn_pwm.sv
// Bench for modn_pwm: directed count sequences, a per-cycle expected queue
// drained by a monitor, and hand-computed per-period high-time checks.
module tb_modn_pwm;

  localparam int N = 10;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [W-1:0] cnt_in;
  logic [W-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm_out;
  logic         period_start;
  logic [7:0]   periods;
  logic         cnt_err;
  logic         dbg_state;

  modn_pwm #(.N(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cnt_in       (cnt_in),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .periods      (periods),
    .cnt_err      (cnt_err),
    .dbg_state    (dbg_state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int g_cnt  = 0;
  int np     = 0;
  int hi_run = 0;
  int last_hi = 0;
  int cyc    = 0;

  // expected {pwm, period_start, periods[7:0], cnt_err, duty_ready, state}
  logic [12:0] exp_q[$];
  logic [12:0] e;

  bit m_run, m_pending, m_err, m_pwm, m_ps;
  int m_prev, m_active, m_pend_duty, m_periods;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs and predict the outputs after the next edge
  task automatic step(input int cnt, input bit dv, input int duty, input bit rst_n);
    bit bad;
    bit ready;
    @(negedge clk);
    rstn       = rst_n;
    cnt_in     = W'(cnt);
    duty_valid = dv;
    duty_in    = W'(duty);
    if (!rst_n) begin
      m_run = 0; m_pending = 0; m_err = 0; m_pwm = 0; m_ps = 0;
      m_prev = 0; m_active = 0; m_pend_duty = 0; m_periods = 0;
    end else begin
      ready = !m_pending;
      bad   = (cnt > N - 1) || (m_run && cnt != (m_prev + 1) % N);
      if (bad) begin
        m_err = 1; m_pwm = 0; m_ps = 0; m_run = 0;
      end else if (!m_run) begin
        m_pwm = 0;
        m_ps  = (cnt == 0);
        if (cnt == 0) begin
          m_run = 1;
          m_periods = (m_periods + 1) % 256;
        end
      end else begin
        m_pwm = (cnt < m_active);
        m_ps  = (cnt == 0);
        if (cnt == 0) m_periods = (m_periods + 1) % 256;
      end
      if (!bad && m_pending && cnt == N - 1) begin
        m_active  = m_pend_duty;
        m_pending = 0;
      end
      if (dv && ready) begin
        m_pend_duty = (duty > N) ? N : duty;
        m_pending   = 1;
      end
      m_prev = cnt;
    end
    exp_q.push_back({m_pwm, m_ps, 8'(m_periods), m_err, !m_pending, m_run});
  endtask

  task automatic tick();
    step(g_cnt, 1'b0, 0, 1'b1);
    g_cnt = (g_cnt + 1) % N;
  endtask

  task automatic offer(input int duty);
    step(g_cnt, 1'b1, duty, 1'b1);
    g_cnt = (g_cnt + 1) % N;
  endtask

  task automatic run_to(input int target);
    while (g_cnt != target) tick();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Finish the current period, drive the wrap, and check the period just ended.
  task automatic period_check(input int exp_hi, input string name);
    run_to(0);
    tick();
    settle();
    np++;
    chk({name, "_periods"}, periods, np % 256);
    if (exp_hi >= 0) chk({name, "_high"}, last_hi, exp_hi);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", pwm_out, e[12]);
      chk("period_start", period_start, e[11]);
      chk("periods", periods, e[10:3]);
      chk("cnt_err", cnt_err, e[2]);
      chk("duty_ready", duty_ready, e[1]);
      chk("state", dbg_state, e[0]);
    end
    if (period_start === 1'b1) begin
      last_hi = hi_run;
      hi_run  = (pwm_out === 1'b1) ? 1 : 0;
    end else begin
      hi_run += (pwm_out === 1'b1) ? 1 : 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cnt_in = '0; duty_in = '0; duty_valid = 1'b0;
    m_run = 0; m_pending = 0; m_err = 0; m_pwm = 0; m_ps = 0;
    m_prev = 0; m_active = 0; m_pend_duty = 0; m_periods = 0;

    // reset
    step(0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 0, 1'b0);
    settle();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_periods", periods, 0);
    chk("rst_ready", duty_ready, 1);
    chk("rst_err", cnt_err, 0);

    // free-running counter, duty 3 loaded before the first wrap
    g_cnt = 5;
    offer(3);
    period_check(-1, "t1_start");
    period_check(-1, "t1_p1");
    period_check(3, "t1_p2");
    period_check(3, "t1_p3");

    // duty 7 accepted mid-period while 3 is active
    run_to(4);
    offer(7);
    settle();
    chk("t2_ready_low", duty_ready, 0);
    period_check(3, "t2_cur");
    chk("t2_ready_back", duty_ready, 1);
    period_check(7, "t2_next");

    // duty 0, then 12 clamped to 10
    offer(0);
    period_check(7, "t3_before");
    offer(12);
    period_check(0, "t3_zero");
    period_check(10, "t3_full");

    // duty accepted on the cnt_in==9 edge is deferred one wrap
    run_to(9);
    offer(5);
    settle();
    chk("t4_ready_low", duty_ready, 0);
    period_check(10, "t4_cur");
    chk("t4_ready_held", duty_ready, 0);
    period_check(10, "t4_deferred");
    chk("t4_ready_back", duty_ready, 1);
    period_check(5, "t4_applied");

    // count jump 5 -> 8
    run_to(6);
    step(8, 1'b0, 0, 1'b1);
    g_cnt = 9;
    settle();
    chk("t5_err", cnt_err, 1);
    chk("t5_pwm", pwm_out, 0);
    chk("t5_state", dbg_state, 0);
    period_check(-1, "t5_resync");
    chk("t5_err_sticky", cnt_err, 1);
    period_check(-1, "t5_first");
    period_check(5, "t5_resumed");

    // jump 2 -> 4 while the compare would be high
    run_to(3);
    step(4, 1'b0, 0, 1'b1);
    g_cnt = 5;
    settle();
    chk("t5j_pwm", pwm_out, 0);
    chk("t5j_state", dbg_state, 0);
    period_check(-1, "t5j_resync");
    period_check(-1, "t5j_first");
    period_check(5, "t5j_resumed");

    // reset mid-period with a pending duty
    run_to(3);
    offer(2);
    step(g_cnt, 1'b0, 0, 1'b0);
    g_cnt = 5;
    settle();
    chk("t6_ready", duty_ready, 1);
    chk("t6_pwm", pwm_out, 0);
    chk("t6_periods", periods, 0);
    chk("t6_err", cnt_err, 0);
    np = 0;
    offer(4);
    period_check(-1, "t6_start");
    period_check(-1, "t6_p1");
    period_check(4, "t6_p2");

    // out-of-range count
    run_to(7);
    step(12, 1'b0, 0, 1'b1);
    g_cnt = 8;
    settle();
    chk("t7_err", cnt_err, 1);
    chk("t7_pwm", pwm_out, 0);
    chk("t7_state", dbg_state, 0);
    period_check(-1, "t7_resync");
    period_check(-1, "t7_first");
    period_check(4, "t7_resumed");
    chk("t7_err_sticky", cnt_err, 1);

    settle();
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
